// File: rtl/axi_lite_master_arb_if.sv
// Purpose: bundle of requester-side and AXI4-Lite-side signals of the two-port AXI-Lite master arbiter.
// Latency: none (wiring only).
// Backpressure: carried by the req_valid/req_ready and AXI valid/ready pairs; rsp_valid has no backpressure.
//
// Modports:
//   master - view of the arbiter: drives req_ready, rsp_*, aw*, w*, bready, ar*, rready.
//   slave  - view of the environment (requesters + AXI slave): drives the opposite set.
interface axi_lite_master_arb_if;
    // requester side
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    // AXI4-Lite write address / data / response
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    // AXI4-Lite read address / data
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp,
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready
    );
endinterface

// File: rtl/axi_lite_master_arb.sv
// Purpose: arbitrates two command requesters onto one AXI4-Lite master port, one transaction outstanding.
// Latency: grant (req_ready pulse) to rsp_valid is 4 cycles minimum with zero-wait slaves.
// Backpressure: requesters hold req_valid until req_ready; AXI valids held until handshake; rsp_valid is not backpressured.
//
// Ports: aclk, aresetn (async, active-low) plus bus (axi_lite_master_arb_if.master) carrying
//        req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb, rsp_valid/rsp_rdata/rsp_resp
//        and the AXI4-Lite AW/W/B/AR/R channels.
// Build option: define AXI_ARB_FIXED_PRIO_EN to make requester 0 win every tie (default: round-robin).
module axi_lite_master_arb (
    input  logic                         aclk,
    input  logic                         aresetn,
    axi_lite_master_arb_if.master        bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic        owner;          // requester that owns the in-flight transaction
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;

    logic        grant_id;
    logic [1:0]  grant;

`ifndef AXI_ARB_FIXED_PRIO_EN
    logic        last_grant;     // requester granted most recently
`endif

    // Arbitration: only meaningful in IDLE, where it doubles as the req_ready pulse.
    always_comb begin
        grant_id = 1'b0;
`ifdef AXI_ARB_FIXED_PRIO_EN
        grant_id = ~bus.req_valid[0];
`else
        if (&bus.req_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = bus.req_valid[1];
        end
`endif
        grant = 2'b00;
        if ((state == IDLE) && (|bus.req_valid)) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    // The FSM already sits in IDLE during reset, so a requester raising valid
    // early would otherwise see a ready pulse while the block is held in reset.
    assign bus.req_ready = aresetn ? grant : 2'b00;

    assign bus.awvalid   = awvalid_q;
    assign bus.awaddr    = addr_q;
    assign bus.awprot    = 1'b0;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.bready    = (state == WR_RESP);
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = addr_q;
    assign bus.arprot    = 1'b0;
    assign bus.rready    = (state == RD_DATA);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;

`ifndef AXI_ARB_FIXED_PRIO_EN
    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= 1'b1;
        end else if ((state == IDLE) && (|bus.req_valid)) begin
            last_grant <= grant_id;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            owner       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 32'h0;
            rsp_resp_q  <= 2'b00;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner   <= grant_id;
                        addr_q  <= grant_id ? bus.req_addr[63:32]  : bus.req_addr[31:0];
                        wdata_q <= grant_id ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
                        wstrb_q <= grant_id ? bus.req_wstrb[7:4]   : bus.req_wstrb[3:0];
                        if (bus.req_write[grant_id]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; a channel whose valid is
                    // already low counts as done.
                    if (awvalid_q && bus.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && bus.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) begin
                        state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_resp_q  <= bus.bresp;
                        state       <= DONE;
                    end
                end
                RD_REQ: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        rsp_rdata_q <= bus.rdata;
                        rsp_resp_q  <= bus.rresp;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Completion is issued from a flop so rsp_valid never
                    // depends combinationally on the AXI response inputs.
                    rsp_valid_q <= owner ? 2'b10 : 2'b01;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_arb.sv
module tb_axi_lite_master_arb;

    logic aclk = 1'b0;
    logic aresetn;

    axi_lite_master_arb_if bus();

    axi_lite_master_arb dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // slave behaviour knobs (written only by the test)
    int          cfg_aw_d  = 0;
    int          cfg_w_d   = 0;
    int          cfg_ar_d  = 0;
    bit          cfg_rhold = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    logic [1:0]  cfg_resp  = 2'd0;

    // observations (written only by the negedge slave/monitor)
    int          grant_cnt = 0, grant_cyc = 0;
    int          rsp_cnt = 0, rsp_cyc = 0;
    logic [1:0]  rsp_vec = 2'b00, rsp_resp_s = 2'b00;
    logic [31:0] rsp_rdata_s = 32'h0;
    int          grant_log[$];
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic [31:0] aw_addr_s = 32'h0, w_data_s = 32'h0, ar_addr_s = 32'h0;
    logic [3:0]  w_strb_s = 4'h0;
    logic        aw_hs_wvalid = 1'b0;
    int          stab_err = 0, order_err = 0, rready_cyc_cnt = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
    bit          aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [31:0] aw_prev = 0, w_prev = 0, ar_prev = 0;
    logic [3:0]  ws_prev = 0;

    // AXI slave model + monitor. Runs on the falling edge: it reads DUT
    // outputs and sets slave inputs for the next rising edge.
    always @(negedge aclk) begin
        if (bus.rsp_valid != 2'b00) begin
            rsp_cnt++;
            rsp_cyc     = cyc;
            rsp_vec     = bus.rsp_valid;
            rsp_rdata_s = bus.rsp_rdata;
            rsp_resp_s  = bus.rsp_resp;
        end
        if (bus.req_ready != 2'b00) begin
            grant_cnt++;
            grant_cyc = cyc;
            grant_log.push_back(bus.req_ready[1] ? 1 : 0);
        end
        if (!aresetn) begin
            bus.awready = 0; bus.wready = 0; bus.arready = 0;
            bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (bus.rready) rready_cyc_cnt++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) order_err++;
            if (aw_pend && (!bus.awvalid || bus.awaddr != aw_prev)) stab_err++;
            if (w_pend && (!bus.wvalid || bus.wdata != w_prev || bus.wstrb != ws_prev)) stab_err++;
            if (ar_pend && (!bus.arvalid || bus.araddr != ar_prev)) stab_err++;
            // retire responses accepted at the last rising edge
            if (b_fire) begin bus.bvalid = 0; b_fire = 0; end
            if (r_fire) begin bus.rvalid = 0; r_fire = 0; end
            // answer address/data handshakes completed at the last rising edge
            if (aw_got && w_got) begin
                bus.bvalid = 1; bus.bresp = cfg_resp; aw_got = 0; w_got = 0;
            end
            if (ar_got && !cfg_rhold) begin
                bus.rvalid = 1; bus.rdata = cfg_rdata; bus.rresp = cfg_resp; ar_got = 0;
            end
            if (bus.bvalid && bus.bready) b_fire = 1;
            if (bus.rvalid && bus.rready) r_fire = 1;
            if (bus.awvalid) begin
                bus.awready = (aw_cnt >= cfg_aw_d); aw_cnt++;
                if (bus.awready) begin
                    aw_got = 1; aw_hs++; aw_addr_s = bus.awaddr; aw_hs_wvalid = bus.wvalid;
                end
            end else begin
                bus.awready = 0; aw_cnt = 0;
            end
            if (bus.wvalid) begin
                bus.wready = (w_cnt >= cfg_w_d); w_cnt++;
                if (bus.wready) begin
                    w_got = 1; w_hs++; w_data_s = bus.wdata; w_strb_s = bus.wstrb;
                end
            end else begin
                bus.wready = 0; w_cnt = 0;
            end
            if (bus.arvalid) begin
                bus.arready = (ar_cnt >= cfg_ar_d); ar_cnt++;
                if (bus.arready) begin
                    ar_got = 1; ar_hs++; ar_addr_s = bus.araddr;
                end
            end else begin
                bus.arready = 0; ar_cnt = 0;
            end
            aw_pend = bus.awvalid && !bus.awready; aw_prev = bus.awaddr;
            w_pend  = bus.wvalid && !bus.wready;   w_prev = bus.wdata; ws_prev = bus.wstrb;
            ar_pend = bus.arvalid && !bus.arready; ar_prev = bus.araddr;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (id == 0) begin
            bus.req_write[0] = wr; bus.req_addr[31:0] = a;
            bus.req_wdata[31:0] = d; bus.req_wstrb[3:0] = s;
        end else begin
            bus.req_write[1] = wr; bus.req_addr[63:32] = a;
            bus.req_wdata[63:32] = d; bus.req_wstrb[7:4] = s;
        end
    endtask

    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        int          ar_d;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [1:0]  exp_vld;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int g0, r0, aw0, w0, ar0;
        bit ok;
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_ar_d = v.ar_d;
        cfg_rdata = v.rdata; cfg_resp = v.resp;
        g0 = grant_cnt; r0 = rsp_cnt; aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
        @(posedge aclk); #1;
        set_req(v.id, v.wr, v.addr, v.wdata, v.strb);
        bus.req_valid[v.id] = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge aclk); #1;
            if (grant_cnt != g0) begin ok = 1; break; end
        end
        // scribble the request fields: the in-flight transaction must not see this
        bus.req_valid = 2'b00;
        set_req(v.id, ~v.wr, ~v.addr, ~v.wdata, ~v.strb);
        chk({tag, "_grant"}, 64'(ok), 64'd1);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_cnt != r0) begin ok = 1; break; end
            @(posedge aclk); #1;
        end
        chk({tag, "_rsp_seen"}, 64'(ok), 64'd1);
        repeat (3) @(posedge aclk);
        #1;
        chk({tag, "_grant_once"}, 64'(grant_cnt - g0), 64'd1);
        chk({tag, "_rsp_once"}, 64'(rsp_cnt - r0), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_vec), 64'(v.exp_vld));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata_s), 64'(v.exp_rdata));
        chk({tag, "_rsp_resp"}, 64'(rsp_resp_s), 64'(v.exp_resp));
        chk({tag, "_latency"}, 64'(rsp_cyc - grant_cyc), 64'(v.exp_lat));
        if (v.wr) begin
            chk({tag, "_aw_count"}, 64'(aw_hs - aw0), 64'd1);
            chk({tag, "_w_count"}, 64'(w_hs - w0), 64'd1);
            chk({tag, "_ar_count"}, 64'(ar_hs - ar0), 64'd0);
            chk({tag, "_awaddr"}, 64'(aw_addr_s), 64'(v.addr));
            chk({tag, "_wdata"}, 64'(w_data_s), 64'(v.wdata));
            chk({tag, "_wstrb"}, 64'(w_strb_s), 64'(v.strb));
            if (v.aw_d > v.w_d) chk({tag, "_wvalid_dropped_first"}, 64'(aw_hs_wvalid), 64'd0);
        end else begin
            chk({tag, "_ar_count"}, 64'(ar_hs - ar0), 64'd1);
            chk({tag, "_aw_count"}, 64'(aw_hs - aw0), 64'd0);
            chk({tag, "_araddr"}, 64'(ar_addr_s), 64'(v.addr));
        end
    endtask

    vec_t vecs[5];
    vec_t v_after_rst;
    int   rr_exp[4];

    initial begin
        bit ok;
        int g0, r0, rr0, gl0;

        // latency = 4 + extra ready wait (write: max(aw_d, w_d), read: ar_d)
        //          id wr addr          wdata          strb awd wd ard rdata          resp  vld    rdata          resp lat
        vecs[0] = '{0, 1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0,        2'd0, 2'b01, 32'h0,        2'd0, 4};
        vecs[1] = '{1, 0, 32'h20,       32'h0,        4'h0, 0, 0, 3, 32'h12345678, 2'd2, 2'b10, 32'h12345678, 2'd2, 7};
        vecs[2] = '{0, 1, 32'h44,       32'hCAFEF00D, 4'h3, 2, 0, 0, 32'h0,        2'd1, 2'b01, 32'h0,        2'd1, 6};
        vecs[3] = '{1, 1, 32'h80,       32'h0BADC0DE, 4'hC, 0, 3, 0, 32'h0,        2'd3, 2'b10, 32'h0,        2'd3, 7};
        vecs[4] = '{0, 0, 32'h1000,     32'h0,        4'h0, 0, 0, 0, 32'hA5A55A5A, 2'd0, 2'b01, 32'hA5A55A5A, 2'd0, 4};
        v_after_rst = '{1, 0, 32'h24,   32'h0,        4'h0, 0, 0, 1, 32'h0F0F0F0F, 2'd0, 2'b10, 32'h0F0F0F0F, 2'd0, 5};
`ifdef AXI_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 0, 1};
`endif

        // reset state, with both requesters already asking
        aresetn = 1'b0;
        bus.req_valid = 2'b11; bus.req_write = 2'b01;
        bus.req_addr = 64'h0000_0200_0000_0100; bus.req_wdata = 64'h1; bus.req_wstrb = 8'hFF;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_ctrl", 64'({bus.rsp_valid, bus.awvalid, bus.wvalid, bus.bready,
                             bus.arvalid, bus.rready, bus.awprot, bus.arprot}), 64'd0);
        chk("rst_addr", {bus.awaddr, bus.araddr}, 64'd0);
        chk("rst_wdata", 64'({bus.wdata, bus.wstrb}), 64'd0);
        chk("rst_rsp", 64'({bus.rsp_rdata, bus.rsp_resp}), 64'd0);
        bus.req_valid = 2'b00;
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // reset while waiting in RD_DATA
        cfg_ar_d = 0; cfg_rhold = 1'b1;
        g0 = grant_cnt; r0 = rsp_cnt; rr0 = rready_cyc_cnt;
        @(posedge aclk); #1;
        set_req(0, 1'b0, 32'h300, 32'h0, 4'h0);
        bus.req_valid[0] = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge aclk); #1;
            if (grant_cnt != g0) begin ok = 1; break; end
        end
        bus.req_valid = 2'b00;
        chk("midrst_grant", 64'(ok), 64'd1);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (rready_cyc_cnt != rr0) begin ok = 1; break; end
            @(posedge aclk); #1;
        end
        chk("midrst_in_rd_data", 64'(ok), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.awvalid, bus.wvalid,
                                bus.bready, bus.arvalid, bus.rready}), 64'd0);
        chk("midrst_addr", {bus.awaddr, bus.araddr}, 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        cfg_rhold = 1'b0;
        aresetn = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        chk("midrst_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        run_vec(v_after_rst, "after_rst");

        // both requesters asking continuously
        cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_rdata = 32'h55; cfg_resp = 2'd0;
        gl0 = grant_log.size(); r0 = rsp_cnt;
        @(posedge aclk); #1;
        set_req(0, 1'b1, 32'h100, 32'h1111, 4'hF);
        set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
        bus.req_valid = 2'b11;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge aclk); #1;
            if (grant_log.size() - gl0 >= 4) begin ok = 1; break; end
        end
        bus.req_valid = 2'b00;
        chk("rr_four_grants", 64'(ok), 64'd1);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_cnt - r0 == grant_log.size() - gl0) begin ok = 1; break; end
            @(posedge aclk); #1;
        end
        chk("rr_drain", 64'(ok), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (gl0 + i < grant_log.size())
                chk($sformatf("rr_grant%0d", i), 64'(grant_log[gl0 + i]), 64'(rr_exp[i]));
            else
                chk($sformatf("rr_grant%0d_missing", i), 64'd0, 64'd1);
        end

        chk("axi_stability", 64'(stab_err), 64'd0);
        chk("bready_after_aw_w", 64'(order_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
